debug_uart_tx: RTL and testbench

DEBUG_UART_TX -- requirements
Module: debug_uart_tx

---
 rtl/fpg8_pkg.sv | 23 ++
 rtl/uart_tx_byte.sv | 78 +++++++
 rtl/debug_uart_tx.sv | 103 ++++++++++
 tb/tb_debug_uart_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpg8_pkg.sv
// Shared constants for the debug UART: ASCII codes, frame length, FSM encoding
// and the nibble-to-hex-character helper.
package fpg8_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  localparam int FRAME_LEN = 11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_ZERO + {4'h0, n};
    else           return ASCII_A + {4'h0, n - 4'd10};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A start seen on the final stop-bit cycle chains the
// next byte with no idle gap, which is how a multi-byte frame stays contiguous.
module uart_tx_byte
  import fpg8_pkg::*;
#(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  logic [1:0]    state_reg;
  logic [CW-1:0] baud_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          baud_last;

  assign baud_last = (baud_cnt_reg == CW'(BAUD_DIV - 1));
  assign done      = (state_reg == ST_STOP) && baud_last;

  always_comb begin
    tx = 1'b1;
    if (state_reg == ST_START)     tx = 1'b0;
    else if (state_reg == ST_DATA) tx = shift_reg[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
    end else begin
      if (state_reg != ST_IDLE) begin
        baud_cnt_reg <= baud_last ? '0 : baud_cnt_reg + 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          baud_cnt_reg <= '0;
          if (start) begin
            state_reg <= ST_START;
            shift_reg <= data;
          end
        end
        ST_START: begin
          if (baud_last) begin
            state_reg   <= ST_DATA;
            bit_cnt_reg <= '0;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_cnt_reg == 3'd7) state_reg <= ST_STOP;
            else                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
          end
        end
        default: begin
          if (baud_last) begin
            if (start) begin
              state_reg <= ST_START;
              shift_reg <= data;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug trace UART: on each CPU step edge, sends "PPPP DDDD\r\n" (PC and
// display register in hex). Edges arriving mid-frame are dropped and flagged.
module debug_uart_tx
  import fpg8_pkg::*;
#(
  parameter int BAUD_DIV = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [15:0] pc_in,
  input  logic [15:0] disp_in,
  output logic        tx,
  output logic        busy,
  output logic        overrun
);

  generate
    if (BAUD_DIV < 2) begin : g_bad_baud
      $error("debug_uart_tx: BAUD_DIV must be at least 2");
    end
  endgenerate

  logic        sync1_reg, sync2_reg, sync_prev_reg;
  logic        step_edge;
  logic [15:0] pc_snap_reg, disp_snap_reg;
  logic        busy_reg, overrun_reg, launch_reg;
  logic [3:0]  byte_idx_reg;
  logic [3:0]  start_idx;
  logic [7:0]  byte_sel;
  logic        byte_start, byte_done, more_bytes;

  assign step_edge  = sync2_reg && !sync_prev_reg;
  assign more_bytes = (byte_idx_reg < 4'(FRAME_LEN - 1));
  assign byte_start = launch_reg || (byte_done && more_bytes);
  // The byte module latches data as it starts, so select the index being started.
  assign start_idx  = launch_reg ? 4'd0 : byte_idx_reg + 4'd1;
  assign busy       = busy_reg;
  assign overrun    = overrun_reg;

  always_comb begin
    byte_sel = ASCII_LF;
    case (start_idx)
      4'd0:  byte_sel = hex_ascii(pc_snap_reg[15:12]);
      4'd1:  byte_sel = hex_ascii(pc_snap_reg[11:8]);
      4'd2:  byte_sel = hex_ascii(pc_snap_reg[7:4]);
      4'd3:  byte_sel = hex_ascii(pc_snap_reg[3:0]);
      4'd4:  byte_sel = ASCII_SPACE;
      4'd5:  byte_sel = hex_ascii(disp_snap_reg[15:12]);
      4'd6:  byte_sel = hex_ascii(disp_snap_reg[11:8]);
      4'd7:  byte_sel = hex_ascii(disp_snap_reg[7:4]);
      4'd8:  byte_sel = hex_ascii(disp_snap_reg[3:0]);
      4'd9:  byte_sel = ASCII_CR;
      default: byte_sel = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      sync_prev_reg <= 1'b0;
      pc_snap_reg   <= '0;
      disp_snap_reg <= '0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
      launch_reg    <= 1'b0;
      byte_idx_reg  <= '0;
    end else begin
      sync1_reg     <= step;
      sync2_reg     <= sync1_reg;
      sync_prev_reg <= sync2_reg;
      launch_reg    <= 1'b0;
      if (step_edge && !busy_reg) begin
        pc_snap_reg   <= pc_in;
        disp_snap_reg <= disp_in;
        busy_reg      <= 1'b1;
        launch_reg    <= 1'b1;
        byte_idx_reg  <= '0;
      end else if (step_edge) begin
        overrun_reg <= 1'b1;
      end
      if (byte_done) begin
        if (more_bytes) begin
          byte_idx_reg <= byte_idx_reg + 4'd1;
        end else begin
          byte_idx_reg <= '0;
          busy_reg     <= 1'b0;
        end
      end
    end
  end

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_byte (
    .clk   (clk),
    .reset (reset),
    .start (byte_start),
    .data  (byte_sel),
    .tx    (tx),
    .done  (byte_done)
  );

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx at BAUD_DIV=4: directed frames, expected bytes queued
// by the stimulus and checked by an independent line monitor.
module tb_debug_uart_tx;

  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        step;
  logic [15:0] pc_in, disp_in;
  logic        tx_w, busy_w, overrun_w;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  debug_uart_tx #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .reset   (reset),
    .step    (step),
    .pc_in   (pc_in),
    .disp_in (disp_in),
    .tx      (tx_w),
    .busy    (busy_w),
    .overrun (overrun_w)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  task automatic push_model(input logic [15:0] pc, input logic [15:0] dv);
    exp_q.push_back(hx(pc[15:12])); exp_q.push_back(hx(pc[11:8]));
    exp_q.push_back(hx(pc[7:4]));   exp_q.push_back(hx(pc[3:0]));
    exp_q.push_back(8'h20);
    exp_q.push_back(hx(dv[15:12])); exp_q.push_back(hx(dv[11:8]));
    exp_q.push_back(hx(dv[7:4]));   exp_q.push_back(hx(dv[3:0]));
    exp_q.push_back(8'h0D);         exp_q.push_back(8'h0A);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic pulse_step(input int hi);
    @(negedge clk);
    step = 1'b1;
    repeat (hi) @(negedge clk);
    step = 1'b0;
  endtask

  // Waits for busy, checks the start bit follows one cycle later, and times busy.
  task automatic measure_frame(input string name);
    int n;
    int w;
    w = 0;
    while (busy_w !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (busy_w !== 1'b1) begin
      check({name, "_busy_rise_timeout"}, 0, 1);
      return;
    end
    check({name, "_tx_idle_in_snapshot_cycle"}, tx_w, 1);
    @(negedge clk);
    check({name, "_start_bit_after_snapshot"}, tx_w, 0);
    n = 1;
    while (busy_w === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, n, 110 * BD + 1);
    $display("[TB] frame %s: busy %0d cycles", name, n);
  endtask

  // Monitor: samples every cycle of each bit, so width and position are both checked.
  initial begin : monitor
    logic [9:0] bits;
    logic       bad, aborted;
    logic [7:0] got, exp;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx_w === 1'b0) begin
        bad = 1'b0;
        aborted = 1'b0;
        bits = '0;
        for (int k = 0; k < 10; k++) begin
          for (int c = 0; c < BD; c++) begin
            if (!(k == 0 && c == 0)) @(negedge clk);
            if (reset !== 1'b1) aborted = 1'b1;
            if (c == 0) bits[k] = tx_w;
            else if (tx_w !== bits[k]) bad = 1'b1;
          end
        end
        if (!aborted) begin
          got = bits[8:1];
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got %02h, expected none", got);
          end else begin
            exp = exp_q.pop_front();
            check("byte_value", {22'h0, bits}, {22'h0, 1'b1, exp, 1'b0});
            check("bit_width_stable", bad, 0);
            $display("[TB] byte %02h (expected %02h)", got, exp);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    step = 1'b0;
    pc_in = '0;
    disp_in = '0;
    #1;
    check("reset_tx", tx_w, 1);
    check("reset_busy", busy_w, 0);
    check("reset_overrun", overrun_w, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Frame A with hand-computed bytes
    pc_in = 16'h0012; disp_in = 16'h007E;
    exp_q.push_back(8'h30); exp_q.push_back(8'h30); exp_q.push_back(8'h31);
    exp_q.push_back(8'h32); exp_q.push_back(8'h20); exp_q.push_back(8'h30);
    exp_q.push_back(8'h30); exp_q.push_back(8'h37); exp_q.push_back(8'h45);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    fork
      pulse_step(5);
      measure_frame("A");
    join
    check("A_overrun_clear", overrun_w, 0);
    repeat (20) @(negedge clk);

    // Frame B with hand-computed bytes
    pc_in = 16'hFFFF; disp_in = 16'hA5C3;
    exp_q.push_back(8'h46); exp_q.push_back(8'h46); exp_q.push_back(8'h46);
    exp_q.push_back(8'h46); exp_q.push_back(8'h20); exp_q.push_back(8'h41);
    exp_q.push_back(8'h35); exp_q.push_back(8'h43); exp_q.push_back(8'h33);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    fork
      pulse_step(5);
      measure_frame("B");
    join
    repeat (20) @(negedge clk);

    // Snapshot holds while pc_in changes mid-frame
    pc_in = 16'h0ABC; disp_in = 16'h0001;
    push_model(16'h0ABC, 16'h0001);
    fork
      measure_frame("snap");
      begin
        pulse_step(5);
        repeat (50) @(negedge clk);
        pc_in = 16'h1234;
        disp_in = 16'hFFFF;
      end
    join
    repeat (20) @(negedge clk);

    // Overrun: second edge mid-frame is dropped
    pc_in = 16'h0001; disp_in = 16'h0002;
    push_model(16'h0001, 16'h0002);
    fork
      measure_frame("ovr");
      begin
        pulse_step(5);
        repeat (100) @(negedge clk);
        pulse_step(5);
        repeat (10) @(negedge clk);
        check("overrun_set", overrun_w, 1);
      end
    join
    repeat (100) @(negedge clk);
    check("no_second_frame", busy_w, 0);
    pc_in = 16'hBEEF; disp_in = 16'h0000;
    push_model(16'hBEEF, 16'h0000);
    fork
      pulse_step(5);
      measure_frame("after_ovr");
    join
    check("overrun_sticky", overrun_w, 1);
    repeat (20) @(negedge clk);

    // Step held high: one frame only
    pc_in = 16'h5A5A; disp_in = 16'h9009;
    push_model(16'h5A5A, 16'h9009);
    fork
      pulse_step(2000);
      measure_frame("held");
    join
    repeat (10) @(negedge clk);
    check("held_single_frame_idle", busy_w, 0);
    check("held_queue_drained", exp_q.size(), 0);

    // Reset during byte 5 (start bit)
    pc_in = 16'h4321; disp_in = 16'h0000;
    push_model(16'h4321, 16'h0000);
    begin : rst_test
      int w;
      pulse_step(5);
      w = 0;
      while (busy_w !== 1'b1 && w < 40) begin
        @(negedge clk);
        w++;
      end
      check("rst_busy_seen", busy_w, 1);
      repeat (1 + 5 * 10 * BD + 1) @(negedge clk);
      check("rst_byte5_start_low", tx_w, 0);
      #2;
      reset = 1'b0;
      #1;
      check("rst_async_tx", tx_w, 1);
      check("rst_async_busy", busy_w, 0);
      check("rst_overrun_cleared", overrun_w, 0);
      exp_q.delete();
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (60) @(negedge clk);
      check("rst_no_resume", busy_w, 0);
    end
    pc_in = 16'h0003; disp_in = 16'h0000;
    push_model(16'h0003, 16'h0000);
    fork
      pulse_step(5);
      measure_frame("post_rst");
    join

    repeat (60) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
